sample_rate_gen: RTL and testbench



---
 rtl/sample_rate_pkg.sv | 23 ++
 rtl/frac_divider.sv | 39 +++
 rtl/sample_rate_gen.sv | 102 ++++++++++
 tb/tb_sample_rate_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_rate_pkg.sv
// Shared types, rate table and increment helper for the fractional-N sample timing generator.
package sample_rate_pkg;

  typedef enum logic [1:0] {
    RATE_48K  = 2'd0,
    RATE_44K1 = 2'd1,
    RATE_32K  = 2'd2,
    RATE_96K  = 2'd3
  } rate_sel_t;

  typedef enum logic {
    IDLE_S = 1'b0,
    RUN_S  = 1'b1
  } state_t;

  localparam int unsigned RATE_HZ [4] = '{48_000, 44_100, 32_000, 96_000};

  // Phase increment per clock: one os_tick is owed every CLK_HZ units of phase.
  function automatic int unsigned rate_inc(rate_sel_t sel, int unsigned osr);
    return RATE_HZ[sel] * osr;
  endfunction

endpackage

// File: rtl/frac_divider.sv
// Phase accumulator: adds inc each running cycle and flags a tick whenever a full CLK_HZ of phase is crossed.
module frac_divider #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned ACC_W  = 27
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             tick_c_o
);

  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum_c;
  logic             wrap_c;

  // acc < CLK_HZ and inc < CLK_HZ, so the sum never exceeds ACC_W bits.
  always_comb begin
    sum_c    = acc_q + inc_i;
    wrap_c   = (sum_c >= LIMIT);
    acc_d    = wrap_c ? (sum_c - LIMIT) : sum_c;
    tick_c_o = run_i & wrap_c;
    if (!run_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/sample_rate_gen.sv
// Fractional-N sample timing generator: os_tick at fs*OSR, sample_tick and lrclk at fs,
// with frame-aligned runtime rate switching.
module sample_rate_gen
  import sample_rate_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned OSR    = 64,
  parameter int unsigned ACC_W  = 27
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    enable,
  input  logic [1:0]              rate_sel,
  output logic                    rate_ack,
  output logic                    os_tick,
  output logic                    sample_tick,
  output logic                    lrclk,
  output logic [$clog2(OSR)-1:0]  os_cnt
);

  localparam int unsigned CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OSR / 2);

  if ((OSR % 2) != 0 || OSR < 2 || OSR > 520) begin : g_osr_range_chk
    $error("sample_rate_gen: OSR must be even and within 2..520");
  end
  if (64'(96_000) * 64'(OSR) >= 64'(CLK_HZ)) begin : g_osr_rate_chk
    $error("sample_rate_gen: 96000*OSR must be below CLK_HZ");
  end
  if (64'(ACC_W) < 64'($clog2(64'(2) * 64'(CLK_HZ)))) begin : g_acc_w_chk
    $error("sample_rate_gen: ACC_W too narrow for 2*CLK_HZ");
  end

  state_t           state_q;
  rate_sel_t        active_q;
  rate_sel_t        pend_rate_q;
  logic             pend_valid_q;
  logic             applied_q;

  logic [ACC_W-1:0] inc_c;
  logic             tick_c;
  logic             last_c;
  logic             frame_end_c;
  logic             apply_c;
  logic [CNT_W-1:0] cnt_next_c;

  frac_divider #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_frac_divider (
    .clk_i    (Clk),
    .reset_i  (Reset),
    .run_i    (enable),
    .inc_i    (inc_c),
    .tick_c_o (tick_c)
  );

  // Frame bookkeeping for the tick about to be registered.
  always_comb begin
    inc_c       = ACC_W'(rate_inc(active_q, OSR));
    last_c      = (os_cnt == LAST);
    frame_end_c = tick_c & last_c;
    apply_c     = frame_end_c & pend_valid_q;
    cnt_next_c  = os_cnt;
    if (tick_c) begin
      cnt_next_c = last_c ? '0 : os_cnt + CNT_W'(1);
    end
  end

  // Rate switches only land on a frame boundary; the accumulator keeps its phase.
  always_ff @(posedge Clk) begin
    if (Reset || !enable) begin
      state_q      <= IDLE_S;
      active_q     <= rate_sel_t'(rate_sel);
      pend_rate_q  <= RATE_48K;
      pend_valid_q <= 1'b0;
      applied_q    <= 1'b0;
      rate_ack     <= 1'b0;
      os_tick      <= 1'b0;
      sample_tick  <= 1'b0;
      lrclk        <= 1'b0;
      os_cnt       <= '0;
    end else begin
      state_q     <= RUN_S;
      os_tick     <= tick_c;
      sample_tick <= frame_end_c;
      os_cnt      <= cnt_next_c;
      lrclk       <= (cnt_next_c >= HALF);
      applied_q   <= apply_c;
      rate_ack    <= applied_q;
      if (apply_c) begin
        active_q     <= pend_rate_q;
        pend_valid_q <= 1'b0;
      end else if (state_q == RUN_S) begin
        pend_rate_q  <= rate_sel_t'(rate_sel);
        pend_valid_q <= (rate_sel_t'(rate_sel) != active_q);
      end
    end
  end

endmodule

// File: tb/tb_sample_rate_gen.sv
// Bench for sample_rate_gen: cycle-by-cycle reference model plus table-driven rate runs and corner sequences.
`timescale 1ns/1ps
module tb_sample_rate_gen;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned OSR_A  = 64;
  localparam int unsigned OSR_B  = 2;
  localparam int unsigned FS_TB [4] = '{48000, 44100, 32000, 96000};

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       reset_a, enable_a, rate_ack_a, os_tick_a, sample_tick_a, lrclk_a;
  logic [1:0] rate_sel_a;
  logic [5:0] os_cnt_a;
  logic       reset_b, enable_b, rate_ack_b, os_tick_b, sample_tick_b, lrclk_b;
  logic [1:0] rate_sel_b;
  logic [0:0] os_cnt_b;

  sample_rate_gen #(.CLK_HZ(CLK_HZ), .OSR(OSR_A), .ACC_W(27)) dut_a (
    .Clk(Clk), .Reset(reset_a), .enable(enable_a), .rate_sel(rate_sel_a),
    .rate_ack(rate_ack_a), .os_tick(os_tick_a), .sample_tick(sample_tick_a),
    .lrclk(lrclk_a), .os_cnt(os_cnt_a));

  sample_rate_gen #(.CLK_HZ(CLK_HZ), .OSR(OSR_B), .ACC_W(27)) dut_b (
    .Clk(Clk), .Reset(reset_b), .enable(enable_b), .rate_sel(rate_sel_b),
    .rate_ack(rate_ack_b), .os_tick(os_tick_b), .sample_tick(sample_tick_b),
    .lrclk(lrclk_b), .os_cnt(os_cnt_b));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state: unbounded phase, total os_ticks since start, requested rate.
  longint unsigned m_ph;
  int  m_nos, m_rate, m_req_sel;
  bit  m_was_run, m_req_valid, m_applied;
  bit  e_os, e_st, e_lr, e_ack;
  int  e_cnt;

  // Observed statistics for dut_a.
  int run_edge, os_seen, st_seen, ack_seen, first_edge, last_tick, last_st, min_sp, max_sp;

  typedef struct {
    int rate; int cycles; int first; int n_os; int n_st; int sp_min; int sp_max; int st_last;
  } vec_t;
  vec_t tbl [4];

  function automatic longint unsigned model_inc();
    return longint'(FS_TB[m_rate]) * OSR_A;
  endfunction

  function automatic bit model_will_tick();
    return ((m_ph + model_inc()) / CLK_HZ) > (m_ph / CLK_HZ);
  endfunction

  task automatic model_edge();
    bit tick, sample, apply;
    if (reset_a || !enable_a) begin
      m_ph = 0; m_nos = 0; m_rate = int'(rate_sel_a); m_was_run = 0;
      m_req_valid = 0; m_applied = 0;
      e_os = 0; e_st = 0; e_lr = 0; e_ack = 0; e_cnt = 0;
    end else begin
      tick = model_will_tick();
      m_ph += model_inc();
      if (tick) m_nos++;
      sample = tick && ((m_nos % OSR_A) == 0);
      e_ack = m_applied;
      apply = sample && m_req_valid && (m_req_sel != m_rate);
      m_applied = apply;
      if (apply) begin
        m_rate = m_req_sel;
        m_req_valid = 0;
      end else if (m_was_run) begin
        m_req_sel = int'(rate_sel_a);
        m_req_valid = 1;
      end
      m_was_run = 1;
      e_os = tick; e_st = sample; e_cnt = m_nos % OSR_A;
      e_lr = (e_cnt >= OSR_A / 2);
    end
  endtask

  task automatic clear_stats();
    run_edge = 0; os_seen = 0; st_seen = 0; ack_seen = 0; first_edge = 0;
    last_tick = 0; last_st = 0; min_sp = 1 << 30; max_sp = 0;
  endtask

  task automatic step();
    bit en;
    int sp;
    en = enable_a && !reset_a;
    model_edge();
    @(posedge Clk); #1;
    cyc++;
    vectors++;
    if ({rate_ack_a, os_tick_a, sample_tick_a, lrclk_a} !== {e_ack, e_os, e_st, e_lr} || int'(os_cnt_a) != e_cnt) begin
      miscompares++;
      $display("FAIL cycle %0d ack/os/st/lr/cnt: got %b%b%b%b/%0d want %b%b%b%b/%0d", cyc,
               rate_ack_a, os_tick_a, sample_tick_a, lrclk_a, os_cnt_a, e_ack, e_os, e_st, e_lr, e_cnt);
    end
    if (en) run_edge++;
    if (os_tick_a) begin
      os_seen++;
      if (first_edge == 0) first_edge = run_edge;
      else begin
        sp = run_edge - last_tick;
        if (sp < min_sp) min_sp = sp;
        if (sp > max_sp) max_sp = sp;
      end
      last_tick = run_edge;
    end
    if (sample_tick_a) begin st_seen++; last_st = run_edge; end
    if (rate_ack_a) ack_seen++;
  endtask

  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic run_until_cnt(input int v, input int bound, input string name);
    int n = 0;
    while (int'(os_cnt_a) != v && n < bound) begin step(); n++; end
    if (int'(os_cnt_a) != v) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, os_cnt got %0d want %0d", name, os_cnt_a, v);
    end
  endtask

  task automatic run_until_st(input int bound, input string name);
    int n = 0;
    do begin step(); n++; end while (!sample_tick_a && n < bound);
    if (!sample_tick_a) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, sample_tick got 0 want 1", name);
    end
  endtask

  task automatic run_until_os(input int bound, input string name);
    int n = 0;
    while (os_seen == 0 && n < bound) begin step(); n++; end
    if (os_seen == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, os_tick got 0 want 1", name);
    end
  endtask

  initial begin
    int prev, prev_sp, sp, h, nst;
    bit hit;

    reset_a = 1; enable_a = 0; rate_sel_a = 2'd0;
    reset_b = 1; enable_b = 0; rate_sel_b = 2'd2;
    clear_stats();

    // Reset state.
    step(); step();
    check("reset_outputs", {rate_ack_a, os_tick_a, sample_tick_a, lrclk_a, os_cnt_a}, 0);

    // Table: each rate at OSR=64 from a clean start.
    tbl[0] = '{0,  3125, 17, 192,  3, 16, 17,  3125};
    tbl[1] = '{1, 12500, 18, 705, 11, 17, 18, 12472};
    tbl[2] = '{2,  3125, 25, 128,  2, 24, 25,  3125};
    tbl[3] = '{3,  3125,  9, 384,  6,  8,  9,  3125};
    for (int i = 0; i < 4; i++) begin
      reset_a = 1; enable_a = 0; rate_sel_a = 2'(tbl[i].rate); step();
      reset_a = 0; step();
      clear_stats();
      enable_a = 1;
      repeat (tbl[i].cycles) step();
      check($sformatf("r%0d_first_os", i), first_edge, tbl[i].first);
      check($sformatf("r%0d_os_count", i), os_seen, tbl[i].n_os);
      check($sformatf("r%0d_st_count", i), st_seen, tbl[i].n_st);
      check($sformatf("r%0d_sp_min", i), min_sp, tbl[i].sp_min);
      check($sformatf("r%0d_sp_max", i), max_sp, tbl[i].sp_max);
      check($sformatf("r%0d_st_last", i), last_st, tbl[i].st_last);
      enable_a = 0; step();
    end

    // 32 kHz at OSR=2: sample edges follow ceil(k*CLK/fs), spacing alternates, lrclk near 50%.
    reset_b = 0; step();
    enable_b = 1;
    prev = 0; prev_sp = 0; h = 0; nst = 0;
    for (int k = 1; k <= 8000; k++) begin
      step();
      if (sample_tick_b) begin
        nst++;
        check("b_st_edge", k, (longint'(nst) * CLK_HZ + 31999) / 32000);
        if (prev != 0) begin
          sp = k - prev;
          if (prev_sp != 0) check("b_st_alternate", (sp != prev_sp), 1);
          check("b_lrclk_duty", ((2 * h - sp) <= 2) && ((2 * h - sp) >= -2), 1);
          prev_sp = sp;
        end
        prev = k; h = 0;
      end else if (lrclk_b) h++;
    end
    check("b_st_count", nst, 5);
    enable_b = 0;

    // Mid-frame 48k -> 96k: old frame completes at full length, ack one cycle after its sample_tick.
    reset_a = 1; rate_sel_a = 2'd0; step();
    reset_a = 0; clear_stats(); enable_a = 1;
    run_until_cnt(10, 1000, "chg_reach_cnt10");
    rate_sel_a = 2'd3;
    run_until_st(2000, "chg_old_frame_end");
    check("chg_old_frame_len", os_seen, 64);
    check("chg_old_sp_max", max_sp, 17);
    os_seen = 0; min_sp = 1 << 30; max_sp = 0;
    step();
    check("chg_rate_ack", rate_ack_a, 1);
    run_until_st(2000, "chg_new_frame_end");
    check("chg_new_frame_len", os_seen, 64);
    check("chg_new_sp_max_le9", (max_sp <= 9), 1);

    // Disable mid-frame, re-enable, then a reverted rate_sel glitch.
    reset_a = 1; rate_sel_a = 2'd0; step();
    reset_a = 0; clear_stats(); enable_a = 1;
    run_until_cnt(40, 2000, "dis_reach_cnt40");
    enable_a = 0; step();
    check("dis_outputs_zero", {rate_ack_a, os_tick_a, sample_tick_a, lrclk_a, os_cnt_a}, 0);
    clear_stats(); enable_a = 1;
    run_until_os(100, "reen_first_os");
    check("reen_first_os_edge", first_edge, 17);
    run_until_st(2000, "glitch_sync");
    rate_sel_a = 2'd1;
    repeat (3) step();
    rate_sel_a = 2'd0;
    ack_seen = 0;
    run_until_st(2000, "glitch_frame1");
    run_until_st(2000, "glitch_frame2");
    step();
    check("glitch_no_ack", ack_seen, 0);

    // Reset on the edge that would produce sample_tick.
    run_until_cnt(63, 2000, "rst_reach_cnt63");
    for (int n = 0; n < 40 && !model_will_tick(); n++) step();
    hit = model_will_tick() && (os_cnt_a == 6'd63);
    check("rst_on_boundary", hit, 1);
    reset_a = 1; step();
    check("rst_outputs_zero", {rate_ack_a, os_tick_a, sample_tick_a, lrclk_a, os_cnt_a}, 0);
    reset_a = 0; clear_stats();
    run_until_os(100, "rst_restart_os");
    check("rst_restart_first_os", first_edge, 17);

    // Randomized enable/reset/rate_sel traffic against the model.
    enable_a = 1;
    for (int n = 0; n < 10000; n++) begin
      reset_a = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 1499) == 0) enable_a = ~enable_a;
      if ($urandom_range(0, 599) == 0) rate_sel_a = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
